// File: rtl/regbank_write_scheduler.sv
// Write-port scheduler for the 8x16 ID-stage register bank: merges ALU and load writebacks
// through an in-order pending buffer. Define REGBANK_FWD_EN to forward pending data instead of stalling.
module regbank_write_scheduler #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_req,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] writeDat,
    output logic              fwd1_valid,
    output logic              fwd2_valid,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= BUF_DEPTH) s = s - BUF_DEPTH;
        return PTR_W'(s);
    endfunction

    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] write_dat_q, write_dat_d;
    logic [ADDR_W-1:0] buf_rd_q   [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_rd_d   [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data_d [BUF_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              ready;
    logic              alu_acc;
    logic              mem_acc;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  push_cnt;
    logic              pop;

    assign ready     = (count_q < DEPTH_C);
    assign alu_ready = ready;
    assign mem_ready = ready;
    assign alu_acc   = alu_req && ready;
    assign mem_acc   = mem_req && ready;

    // Oldest candidate (head, then mem, then alu) goes to the output register; the rest queue in order.
    always_comb begin
        reg_write_d = 1'b0;
        rd_d        = rd_q;
        write_dat_d = write_dat_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        head_d      = head_q;
        wr_ptr      = tail_q;
        push_cnt    = '0;
        pop         = 1'b0;

        if (count_q != '0) begin
            reg_write_d = 1'b1;
            rd_d        = buf_rd_q[head_q];
            write_dat_d = buf_data_q[head_q];
            head_d      = ptr_inc(head_q);
            pop         = 1'b1;
            if (mem_acc) begin
                buf_rd_d[wr_ptr]   = mem_rd;
                buf_data_d[wr_ptr] = mem_data;
                wr_ptr             = ptr_inc(wr_ptr);
                push_cnt           = push_cnt + CNT_W'(1);
            end
            if (alu_acc) begin
                buf_rd_d[wr_ptr]   = alu_rd;
                buf_data_d[wr_ptr] = alu_data;
                wr_ptr             = ptr_inc(wr_ptr);
                push_cnt           = push_cnt + CNT_W'(1);
            end
        end else if (mem_acc) begin
            reg_write_d = 1'b1;
            rd_d        = mem_rd;
            write_dat_d = mem_data;
            if (alu_acc) begin
                buf_rd_d[wr_ptr]   = alu_rd;
                buf_data_d[wr_ptr] = alu_data;
                wr_ptr             = ptr_inc(wr_ptr);
                push_cnt           = push_cnt + CNT_W'(1);
            end
        end else if (alu_acc) begin
            reg_write_d = 1'b1;
            rd_d        = alu_rd;
            write_dat_d = alu_data;
        end

        tail_d  = wr_ptr;
        count_d = count_q + push_cnt - CNT_W'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            write_dat_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_rd_q[i]   <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            write_dat_q <= write_dat_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            buf_rd_q    <= buf_rd_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign RegWrite = reg_write_q;
    assign rd       = rd_q;
    assign writeDat = write_dat_q;

    logic hit1, hit2;
`ifdef REGBANK_FWD_EN
    logic [DATA_W-1:0] hit1_data, hit2_data;
`endif

    // Scan oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] slot;
        hit1 = 1'b0;
        hit2 = 1'b0;
`ifdef REGBANK_FWD_EN
        hit1_data = '0;
        hit2_data = '0;
`endif
        if (reg_write_q) begin
            if (rd_q == rs) begin
                hit1 = 1'b1;
`ifdef REGBANK_FWD_EN
                hit1_data = write_dat_q;
`endif
            end
            if (rd_q == rt) begin
                hit2 = 1'b1;
`ifdef REGBANK_FWD_EN
                hit2_data = write_dat_q;
`endif
            end
        end
        for (int i = 0; i < BUF_DEPTH; i++) begin
            slot = slot_of(head_q, i);
            if (i < int'(count_q)) begin
                if (buf_rd_q[slot] == rs) begin
                    hit1 = 1'b1;
`ifdef REGBANK_FWD_EN
                    hit1_data = buf_data_q[slot];
`endif
                end
                if (buf_rd_q[slot] == rt) begin
                    hit2 = 1'b1;
`ifdef REGBANK_FWD_EN
                    hit2_data = buf_data_q[slot];
`endif
                end
            end
        end
    end

`ifdef REGBANK_FWD_EN
    assign stall      = 1'b0;
    assign fwd1_valid = hit1;
    assign fwd2_valid = hit2;
    assign fwd1_data  = hit1_data;
    assign fwd2_data  = hit2_data;
`else
    assign stall      = hit1 | hit2;
    assign fwd1_valid = 1'b0;
    assign fwd2_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_regbank_write_scheduler.sv
// Directed self-checking bench for regbank_write_scheduler (default build or REGBANK_FWD_EN).
module tb_regbank_write_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_req, mem_req;
    logic [2:0]  alu_rd, mem_rd, rs, rt;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, stall, RegWrite;
    logic [2:0]  rd;
    logic [15:0] writeDat;
    logic        fwd1_valid, fwd2_valid;
    logic [15:0] fwd1_data, fwd2_data;

    int checkCount = 0;
    int failCount  = 0;
    logic [15:0] tbBank [8];
    logic [7:0]  expReady;

    regbank_write_scheduler #(.DATA_W(16), .ADDR_W(3), .BUF_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .alu_req(alu_req), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_req(mem_req), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rs(rs), .rt(rt), .stall(stall),
        .RegWrite(RegWrite), .rd(rd), .writeDat(writeDat),
        .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
    );

    always #5 clock = ~clock;

    // Bank model: a write visible during a cycle commits at that cycle's end.
    always @(negedge clock) begin
        if (!reset && RegWrite) tbBank[rd] <= writeDat;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic mReq, input logic [2:0] mRd, input logic [15:0] mDat,
                                 input logic aReq, input logic [2:0] aRd, input logic [15:0] aDat);
        mem_req  = mReq; mem_rd = mRd; mem_data = mDat;
        alu_req  = aReq; alu_rd = aRd; alu_data = aDat;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tbBank[i] = 16'h0000;
        reset = 1'b1;
        rs = 3'd7; rt = 3'd7;
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        repeat (2) @(negedge clock);
        checkOutput("rst_regwrite", RegWrite, 0);
        checkOutput("rst_rd", rd, 0);
        checkOutput("rst_wdat", writeDat, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_fwd1", fwd1_valid, 0);
        reset = 1'b0;

        // Single write
        @(negedge clock);
        checkOutput("single_ready", alu_ready, 1);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
        @(negedge clock);
        checkOutput("single_we", RegWrite, 1);
        checkOutput("single_rd", rd, 3);
        checkOutput("single_dat", writeDat, 16'h1234);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        @(negedge clock);
        checkOutput("single_we_off", RegWrite, 0);
        checkOutput("single_rd_hold", rd, 3);
        checkOutput("single_dat_hold", writeDat, 16'h1234);

        // Collision on the same destination
        applyStimulus(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5, 16'h5555);
        @(negedge clock);
        checkOutput("coll1_we", RegWrite, 1);
        checkOutput("coll1_rd", rd, 5);
        checkOutput("coll1_dat", writeDat, 16'hAAAA);
        checkOutput("coll1_ready", mem_ready, 1);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        @(negedge clock);
        checkOutput("coll2_we", RegWrite, 1);
        checkOutput("coll2_rd", rd, 5);
        checkOutput("coll2_dat", writeDat, 16'h5555);
        @(negedge clock);
        checkOutput("coll_idle", RegWrite, 0);
        @(negedge clock);
        checkOutput("coll_bank_r5", tbBank[5], 16'h5555);

        // Hazard on rs
        rs = 3'd2;
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h0BEE);
        #1 checkOutput("haz_accept_stall", stall, 0);
        @(negedge clock);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        checkOutput("haz_we", RegWrite, 1);
`ifdef REGBANK_FWD_EN
        checkOutput("haz_stall", stall, 0);
        checkOutput("haz_fwd1_valid", fwd1_valid, 1);
        checkOutput("haz_fwd1_data", fwd1_data, 16'h0BEE);
`else
        checkOutput("haz_stall", stall, 1);
        checkOutput("haz_fwd1_valid", fwd1_valid, 0);
`endif
        @(negedge clock);
        checkOutput("haz_clear", stall, 0);
        rs = 3'd7;

        // Backpressure: pairs 1/2, 3/4, 5/6 held until accepted
        rt = 3'd4;
        expReady = 8'b0010_1011;
        for (int i = 0; i <= 7; i++) begin
            if (i >= 1 && i <= 6) begin
                checkOutput($sformatf("bp_we_%0d", i), RegWrite, 1);
                checkOutput($sformatf("bp_rd_%0d", i), rd, i);
                checkOutput($sformatf("bp_dat_%0d", i), writeDat, 16'h1000 + i);
            end
            if (i <= 5) begin
                checkOutput($sformatf("bp_ready_%0d", i), alu_ready, expReady[i]);
                checkOutput($sformatf("bp_mready_%0d", i), mem_ready, expReady[i]);
            end
            if (i == 2) begin
`ifdef REGBANK_FWD_EN
                checkOutput("bp_fwd2_valid", fwd2_valid, 1);
                checkOutput("bp_fwd2_data", fwd2_data, 16'h1004);
`else
                checkOutput("bp_stall_buf", stall, 1);
`endif
            end
            case (i)
                0:       applyStimulus(1'b1, 3'd1, 16'h1001, 1'b1, 3'd2, 16'h1002);
                1:       applyStimulus(1'b1, 3'd3, 16'h1003, 1'b1, 3'd4, 16'h1004);
                2, 3:    applyStimulus(1'b1, 3'd5, 16'h1005, 1'b1, 3'd6, 16'h1006);
                default: applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
            endcase
            @(negedge clock);
        end
        checkOutput("bp_idle", RegWrite, 0);
        checkOutput("bp_stall_done", stall, 0);
        for (int i = 1; i <= 6; i++)
            checkOutput($sformatf("bp_bank_r%0d", i), tbBank[i], 16'h1000 + i);
        rt = 3'd7;

        // Reset mid-burst with two buffered entries
        applyStimulus(1'b1, 3'd1, 16'h2001, 1'b1, 3'd2, 16'h2002);
        @(negedge clock);
        applyStimulus(1'b1, 3'd3, 16'h2003, 1'b1, 3'd4, 16'h2004);
        @(negedge clock);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        rs = 3'd3;
        #1 checkOutput("mid_full_ready", alu_ready, 0);
`ifndef REGBANK_FWD_EN
        checkOutput("mid_stall", stall, 1);
`endif
        #1 reset = 1'b1;
        #1;
        checkOutput("mid_rst_we", RegWrite, 0);
        checkOutput("mid_rst_rd", rd, 0);
        checkOutput("mid_rst_dat", writeDat, 0);
        checkOutput("mid_rst_stall", stall, 0);
        checkOutput("mid_rst_fwd1", fwd1_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("mid_post_aready", alu_ready, 1);
        checkOutput("mid_post_mready", mem_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput($sformatf("mid_dropped_%0d", i), RegWrite, 0);
        end
        checkOutput("mid_bank_r3", tbBank[3], 16'h1003);
        checkOutput("mid_bank_r4", tbBank[4], 16'h1004);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
